tt_um_lfsr_encrypt: RTL and testbench

TT_UM_LFSR_ENCRYPT -- requirements
Module: tt_um_lfsr_encrypt

---
 rtl/lfsr_encrypt_pkg.sv | 28 ++
 rtl/lfsr_encrypt_step_n.sv | 18 +
 rtl/tt_um_lfsr_encrypt.sv | 78 +++++++
 tb/tb_tt_um_lfsr_encrypt.sv | 139 +++++++++++++
 4 files changed

// File: rtl/lfsr_encrypt_pkg.sv
// Shared constants and the single-step LFSR function for the LFSR stream cipher tile.
package lfsr_encrypt_pkg;

  localparam int unsigned LFSR_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 16'hACE1;

  // Taps for x^16 + x^14 + x^13 + x^11 + 1 in a left-shifting Fibonacci register
  localparam int unsigned TAP_A = 15;
  localparam int unsigned TAP_B = 13;
  localparam int unsigned TAP_C = 12;
  localparam int unsigned TAP_D = 10;

  // uio bit positions
  localparam int unsigned UIO_LOAD_LO   = 0;
  localparam int unsigned UIO_LOAD_HI   = 1;
  localparam int unsigned UIO_VALID     = 2;
  localparam int unsigned UIO_OUT_VALID = 4;
  localparam int unsigned UIO_SEEDED    = 5;
  localparam logic [BYTE_W-1:0] UIO_OE_VALUE = 8'hF0;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    logic fb;
    fb = s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
    return {s[LFSR_W-2:0], fb};
  endfunction

endpackage

// File: rtl/lfsr_encrypt_step_n.sv
// Combinational advance of the LFSR state by STEPS single steps.
module lfsr_step_n
  import lfsr_encrypt_pkg::*;
#(
  parameter int unsigned STEPS = 8
) (
  input  logic [LFSR_W-1:0] state,
  output logic [LFSR_W-1:0] state_c
);

  always_comb begin
    state_c = state;
    for (int unsigned i = 0; i < STEPS; i++) begin
      state_c = lfsr_step(state_c);
    end
  end

endmodule

// File: rtl/tt_um_lfsr_encrypt.sv
// LFSR stream cipher tile: XORs each valid byte with the low LFSR byte, then advances the LFSR.
module tt_um_lfsr_encrypt
  import lfsr_encrypt_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED_DEFAULT   = LFSR_SEED_DEFAULT,
  parameter int unsigned       STEPS_PER_BYTE = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [BYTE_W-1:0] ui_in,
  input  logic [BYTE_W-1:0] uio_in,
  output logic [BYTE_W-1:0] uo_out,
  output logic [BYTE_W-1:0] uio_out,
  output logic [BYTE_W-1:0] uio_oe
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] stepped_c;
  logic [LFSR_W-1:0] loaded_c;
  logic [BYTE_W-1:0] data_q;
  logic              out_valid_q;
  logic              seeded_q;
  logic              load_lo_c;
  logic              load_hi_c;
  logic              valid_c;
  logic              unused_c;

  assign load_lo_c = uio_in[UIO_LOAD_LO];
  assign load_hi_c = uio_in[UIO_LOAD_HI];
  assign valid_c   = uio_in[UIO_VALID];
  assign unused_c  = ^{ena, uio_in[BYTE_W-1:3]};

  lfsr_step_n #(
    .STEPS(STEPS_PER_BYTE)
  ) u_step (
    .state  (lfsr_q),
    .state_c(stepped_c)
  );

  // Seed merge; an all-zero result would lock the LFSR, so fall back to the default seed
  always_comb begin
    loaded_c = lfsr_q;
    if (load_lo_c) loaded_c[BYTE_W-1:0] = ui_in;
    if (load_hi_c) loaded_c[LFSR_W-1:BYTE_W] = ui_in;
    if (loaded_c == '0) loaded_c = SEED_DEFAULT;
  end

  // Loads win over valid; a load cycle neither steps nor emits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q      <= SEED_DEFAULT;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      seeded_q    <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (load_lo_c || load_hi_c) begin
        lfsr_q   <= loaded_c;
        seeded_q <= 1'b1;
      end else if (valid_c) begin
        data_q      <= ui_in ^ lfsr_q[BYTE_W-1:0];
        lfsr_q      <= stepped_c;
        out_valid_q <= 1'b1;
      end
    end
  end

  always_comb begin
    uio_out                = '0;
    uio_out[UIO_OUT_VALID] = out_valid_q;
    uio_out[UIO_SEEDED]    = seeded_q;
  end

  assign uo_out = data_q;
  assign uio_oe = UIO_OE_VALUE;

endmodule

// File: tb/tb_tt_um_lfsr_encrypt.sv
// Directed vector bench for tt_um_lfsr_encrypt with hand-computed keystream values.
module tb_tt_um_lfsr_encrypt;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tt_um_lfsr_encrypt dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  typedef struct {
    logic       rst_n;
    logic       ld_lo;
    logic       ld_hi;
    logic       valid;
    logic [7:0] ui;
    logic [7:0] exp_uo;
    logic       exp_ov;
    logic       exp_sd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic lo, input logic hi, input logic v,
                              input logic [7:0] ui, input logic [7:0] uo,
                              input logic ov, input logic sd);
    vec_t t;
    t.rst_n = r; t.ld_lo = lo; t.ld_hi = hi; t.valid = v;
    t.ui = ui; t.exp_uo = uo; t.exp_ov = ov; t.exp_sd = sd;
    return t;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic lo, input logic hi, input logic v,
                       input logic [7:0] ui);
    rst_n  = r;
    ui_in  = ui;
    uio_in = {5'b11000, v, hi, lo};
    @(posedge clk);
    #1;
  endtask

  initial begin
    ena    = 1'b1;
    rst_n  = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;

    // keystream from reset: E1, E4, 55
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 8'h00, 8'hE1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 8'h00, 8'hE4, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 8'h00, 8'h55, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 8'h77, 8'h55, 0, 0));
    // encrypt "ABC", then decrypt the ciphertext
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 8'h41, 8'hA0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 8'h42, 8'hA6, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 8'h43, 8'h16, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 8'hA0, 8'h41, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 8'hA6, 8'h42, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 8'h16, 8'h43, 1, 0));
    // zero seed on both halves falls back to default
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 8'h00, 8'h00, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 8'h00, 8'hE1, 1, 1));
    // load with valid: load wins, no step
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 8'h5A, 8'h00, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 8'h00, 8'h5A, 1, 1));
    // seed 1212, keystream 12
    vecs.push_back(mk(1, 1, 1, 0, 8'h12, 8'h5A, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 8'hFF, 8'hED, 1, 1));
    // split loads reaching zero: 00E1 then 0000 -> ACE1
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 8'h00, 8'h00, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 8'h00, 8'h00, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 8'h00, 8'hE1, 1, 1));
    vecs.push_back(mk(1, 0, 0, 1, 8'h00, 8'hE4, 1, 1));
    // reset overrides load and valid; reset mid-burst restarts the stream
    vecs.push_back(mk(0, 1, 1, 1, 8'h33, 8'h00, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 8'h00, 8'hE1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 8'h00, 8'hE4, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 8'h00, 8'hE1, 1, 0));

    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].ld_lo, vecs[i].ld_hi, vecs[i].valid, vecs[i].ui);
      check($sformatf("vec%0d uo_out", i), 16'(uo_out), 16'(vecs[i].exp_uo));
      check($sformatf("vec%0d uio_out", i), 16'(uio_out),
            16'({2'b00, vecs[i].exp_sd, vecs[i].exp_ov, 4'b0000}));
      check($sformatf("vec%0d uio_oe", i), 16'(uio_oe), 16'h00F0);
    end

    // internal state after the first byte, and uio_oe while held in reset
    drive(0, 0, 0, 0, 8'h00);
    check("reset state", dut.lfsr_q, 16'hACE1);
    check("oe in reset", 16'(uio_oe), 16'h00F0);
    drive(1, 0, 0, 1, 8'h00);
    check("state after byte", dut.lfsr_q, 16'hE1E4);
    drive(1, 0, 0, 1, 8'h00);
    check("state after 2 bytes", dut.lfsr_q, 16'hE455);
    drive(1, 0, 0, 0, 8'h00);
    check("idle holds state", dut.lfsr_q, 16'hE455);
    drive(1, 1, 0, 1, 8'h5A);
    check("load lo state", dut.lfsr_q, 16'hE45A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
